regfile_scoreboard: RTL and testbench

- Parametrised general-purpose register file for the RV32 core, successor to the single-write / two-read file.
- Adds a configurable read-port count, synchronous reset of all registers, and a per-register busy scoreboard (set at issue, cleared at commit) so decode can detect RAW hazards.
- Adds a scoreboard flush for pipeline redirects.
- Sits between decode/issue (read ports, issue marking) and writeback/LSU (commit writes).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rdport.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 tb/tb_regfile_scoreboard.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the RV32 register file with busy scoreboard.
// RV32 defaults and common register address/data types.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/regfile_rdport.sv
// One read port of the register file: data lookup, busy lookup, x0 masking
// and, when REGFILE_BYPASS_EN is defined, same-cycle write forwarding.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_AW,
  parameter int DATA_WIDTH = XLEN,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] rf,
  input  logic [DEPTH-1:0]                 busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rbusy
);

`ifndef REGFILE_BYPASS_EN
  // Without forwarding the write bus has no effect on reads.
  logic unused_wr;
  assign unused_wr = ^{wr_en, waddr, wdata};
`endif

  // Combinational read with optional forwarding; x0 always reads 0 and idle.
  always_comb begin
    rdata = rf[raddr];
    rbusy = busy[raddr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (waddr == raddr)) begin
      rdata = wdata;
      rbusy = 1'b0;
    end
`endif
    if (raddr == ADDR_WIDTH'(ZERO_REG)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// RV32 register file with NR_READ combinational read ports, one commit write
// port, a per-register busy scoreboard (set at issue, cleared at commit,
// cleared by flush) and a registered count of busy registers.
// Optional feature: define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_AW,
  parameter int DATA_WIDTH = XLEN,
  parameter int NR_READ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          iss_en,
  input  logic [ADDR_WIDTH-1:0]         iss_addr,
  input  logic                          wen,
  input  logic                          wcommit,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          flush,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic wr_commit;
  logic iss_vld;
  logic cnt_inc;
  logic cnt_dec;

  // Qualified write and issue strobes; x0 targets are dropped here.
  always_comb begin
    wr_commit = wen && wcommit && (waddr != ADDR_WIDTH'(ZERO_REG));
    iss_vld   = iss_en && (iss_addr != ADDR_WIDTH'(ZERO_REG));
  end

  // Next register contents: a single committed write per cycle.
  always_comb begin
    rf_d = rf_q;
    if (wr_commit) rf_d[waddr] = wdata;
    rf_d[ZERO_REG] = '0;
  end

  // Next busy vector: flush first, then commit clear, then issue set so the
  // newer producer owns a register that commits and issues in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (flush)          busy_d = '0;
    else if (wr_commit) busy_d[waddr] = 1'b0;
    if (iss_vld)        busy_d[iss_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // Incremental busy count; a flush restarts it from the accompanying issue.
  always_comb begin
    cnt_inc = iss_vld && !busy_q[iss_addr];
    cnt_dec = wr_commit && busy_q[waddr] && !(iss_vld && (iss_addr == waddr));
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = iss_vld ? CNT_W'(1) : '0;
    end else begin
      unique case ({cnt_inc, cnt_dec})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State update; reset dominates every other request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q   <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    regfile_rdport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_rdport (
      .rf    (rf_q),
      .busy  (busy_q),
      .wr_en (wr_commit),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .rdata (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with three read ports.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             wen;
  logic             wcommit;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             flush;
  logic [AW:0]      busy_cnt;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wen      (wen),
    .wcommit  (wcommit),
    .waddr    (waddr),
    .wdata    (wdata),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input reg_data_t got, input reg_data_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0; iss_addr = '0; wen = 1'b0; wcommit = 1'b0;
    waddr = '0; wdata = '0; flush = 1'b0;
  endtask

  task automatic rd_all(input logic [AW-1:0] a);
    for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = a;
    #1;
  endtask

  function automatic reg_data_t rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  function automatic reg_data_t cnt();
    return reg_data_t'(busy_cnt);
  endfunction

  initial begin
    raddr = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every port, every non-zero address.
    for (int a = 1; a < 32; a++) begin
      rd_all(AW'(a));
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("rst_data_a%0d_p%0d", a, p), rd(p), 32'h0);
        chk($sformatf("rst_busy_a%0d_p%0d", a, p), reg_data_t'(rbusy[p]), 32'h0);
      end
    end
    chk("rst_cnt", cnt(), 32'd0);

    // wen without wcommit must not write.
    wen = 1'b1; wcommit = 1'b0; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle();
    rd_all(5'd5);
    chk("nocommit_x5", rd(0), 32'h0);

    // x0: write and issue are both dropped.
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    rd_all(5'd0);
    chk("x0_data", rd(1), 32'h0);
    chk("x0_busy", reg_data_t'(rbusy[1]), 32'h0);
    chk("x0_cnt", cnt(), 32'd0);

    // Issue x7, commit 0x1234 three cycles later.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle();
    rd_all(5'd7);
    chk("x7_c1_busy", reg_data_t'(rbusy[0]), 32'h1);
    chk("x7_c1_cnt", cnt(), 32'd1);
    tick();
    chk("x7_c2_busy", reg_data_t'(rbusy[0]), 32'h1);
    tick();
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd7; wdata = 32'h1234;
    #1;
    chk("x7_c3_busy", reg_data_t'(rbusy[0]), BYP ? 32'h0 : 32'h1);
    chk("x7_c3_data", rd(0), BYP ? 32'h1234 : 32'h0);
    tick();
    idle();
    #1;
    chk("x7_c4_busy", reg_data_t'(rbusy[0]), 32'h0);
    chk("x7_c4_data", rd(0), 32'h1234);
    chk("x7_c4_cnt", cnt(), 32'd0);

    // Same-cycle issue and commit to already-busy x9: new producer keeps it busy.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd9; wdata = 32'h55;
    tick();
    idle();
    rd_all(5'd9);
    chk("x9_data", rd(2), 32'h55);
    chk("x9_busy", reg_data_t'(rbusy[2]), 32'h1);
    chk("x9_cnt", cnt(), 32'd1);

    // Issue x1..x3, then flush together with issue of x4.
    for (int r = 1; r <= 3; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      tick();
    end
    idle();
    chk("pre_flush_cnt", cnt(), 32'd4);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    chk("flush_cnt", cnt(), 32'd1);
    rd_all(5'd4);
    chk("flush_x4_busy", reg_data_t'(rbusy[0]), 32'h1);
    for (int r = 1; r <= 3; r++) begin
      rd_all(AW'(r));
      chk($sformatf("flush_x%0d_busy", r), reg_data_t'(rbusy[1]), 32'h0);
    end
    rd_all(5'd9);
    chk("flush_x9_busy", reg_data_t'(rbusy[1]), 32'h0);

    // Commit to a non-busy register writes data, count unchanged.
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd12; wdata = 32'h99;
    tick();
    idle();
    rd_all(5'd12);
    chk("nb_x12_data", rd(0), 32'h99);
    chk("nb_cnt", cnt(), 32'd1);

    // Repeated issue of busy x4 leaves count alone; its commit drops it to 0.
    iss_en = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    chk("reissue_cnt", cnt(), 32'd1);
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd4; wdata = 32'h44;
    tick();
    idle();
    chk("x4_commit_cnt", cnt(), 32'd0);

    // All three ports on x10 during its commit.
    rd_all(5'd10);
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd10; wdata = 32'hA5A5A5A5;
    #1;
    for (int p = 0; p < NR; p++)
      chk($sformatf("x10_same_p%0d", p), rd(p), BYP ? 32'hA5A5A5A5 : 32'h0);
    tick();
    idle();
    #1;
    for (int p = 0; p < NR; p++)
      chk($sformatf("x10_after_p%0d", p), rd(p), 32'hA5A5A5A5);

    // Reset together with a write and an issue: reset wins.
    rst = 1'b1;
    wen = 1'b1; wcommit = 1'b1; waddr = 5'd10; wdata = 32'h77;
    iss_en = 1'b1; iss_addr = 5'd11;
    tick();
    rst = 1'b0;
    idle();
    rd_all(5'd10);
    chk("rst2_x10", rd(0), 32'h0);
    rd_all(5'd12);
    chk("rst2_x12", rd(1), 32'h0);
    rd_all(5'd11);
    chk("rst2_x11_busy", reg_data_t'(rbusy[2]), 32'h0);
    chk("rst2_cnt", cnt(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
